// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN inference controller and its datapath.
package snn_pkg;

  localparam int unsigned SNN_NUM_CLASSES  = 10;
  localparam int unsigned SNN_COUNT_W      = 6;
  localparam int unsigned SNN_SEL_W        = 4;
  localparam int unsigned SNN_WINDOW_W     = 8;
  localparam int unsigned SNN_CLEAR_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SCAN   = 3'd3,
    ST_RESULT = 3'd4
  } snn_state_e;

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Result valid/ready channel from the inference controller to its consumer.
interface snn_inference_ctrl_if
  import snn_pkg::*;
#(
  parameter int unsigned COUNT_W = SNN_COUNT_W,
  parameter int unsigned SEL_W   = SNN_SEL_W
);

  logic               result_valid_o;
  logic               result_ready_i;
  logic [SEL_W-1:0]   result_class_o;
  logic [COUNT_W-1:0] result_count_o;
  logic               result_tie_o;

  modport master (
    output result_valid_o, result_class_o, result_count_o, result_tie_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o, result_class_o, result_count_o, result_tie_o,
    output result_ready_i
  );

endinterface

// File: rtl/snn_argmax_seq.sv
// Sequential argmax over (index, count) samples; lowest index wins ties, result held until next done.
module snn_argmax_seq
  import snn_pkg::*;
#(
  parameter int unsigned COUNT_W = SNN_COUNT_W,
  parameter int unsigned SEL_W   = SNN_SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               done_i,
  input  logic [SEL_W-1:0]   idx_i,
  input  logic [COUNT_W-1:0] cnt_i,
  output logic [SEL_W-1:0]   best_idx_o,
  output logic [COUNT_W-1:0] best_cnt_o,
  output logic               tie_o
);

  logic [SEL_W-1:0]   run_idx_q, run_idx_d;
  logic [COUNT_W-1:0] run_cnt_q, run_cnt_d;
  logic               run_tie_q, run_tie_d;

  // Running max including the current sample; start seeds it with the first sample.
  always_comb begin
    run_idx_d = run_idx_q;
    run_cnt_d = run_cnt_q;
    run_tie_d = run_tie_q;
    if (start_i) begin
      run_idx_d = idx_i;
      run_cnt_d = cnt_i;
      run_tie_d = 1'b0;
    end else if (step_i) begin
      if (cnt_i > run_cnt_q) begin
        run_idx_d = idx_i;
        run_cnt_d = cnt_i;
        run_tie_d = 1'b0;
      end else if (cnt_i == run_cnt_q) begin
        run_tie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_idx_q  <= '0;
      run_cnt_q  <= '0;
      run_tie_q  <= 1'b0;
      best_idx_o <= '0;
      best_cnt_o <= '0;
      tie_o      <= 1'b0;
    end else begin
      run_idx_q <= run_idx_d;
      run_cnt_q <= run_cnt_d;
      run_tie_q <= run_tie_d;
      if (done_i) begin
        best_idx_o <= run_idx_d;
        best_cnt_o <= run_cnt_d;
        tie_o      <= run_tie_d;
      end
    end
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference: clear, timestep window, counter scan with argmax, result handshake.
// Optional completed-inference counter enabled by defining SNN_CTRL_PERF_CNT_EN.
module snn_inference_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES  = SNN_NUM_CLASSES,
  parameter int unsigned COUNT_W      = SNN_COUNT_W,
  parameter int unsigned WINDOW_W     = SNN_WINDOW_W,
  parameter int unsigned SEL_W        = SNN_SEL_W,
  parameter int unsigned CLEAR_CYCLES = SNN_CLEAR_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [WINDOW_W-1:0] window_len_i,
  output logic                busy_o,
  output logic                net_clear_o,
  output logic                net_en_o,
  output logic [SEL_W-1:0]    cnt_sel_o,
  input  logic [COUNT_W-1:0]  cnt_data_i,
  snn_inference_ctrl_if.master res_if,
  output logic [15:0]         infer_cnt_o
);

  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  snn_state_e          state_q;
  logic [WINDOW_W-1:0] win_q;
  logic [WINDOW_W-1:0] run_cnt_q;
  logic [CLR_W-1:0]    clr_cnt_q;
  logic                busy_q;
  logic                clear_q;
  logic                en_q;
  logic [SEL_W-1:0]    sel_q;
  logic                valid_q;

  logic scan_c;
  logic scan_first_c;
  logic scan_last_c;
  logic handshake_c;

  assign scan_c       = (state_q == ST_SCAN);
  assign scan_first_c = scan_c && (sel_q == '0);
  assign scan_last_c  = scan_c && (sel_q == SEL_W'(NUM_CLASSES - 1));
  assign handshake_c  = (state_q == ST_RESULT) && valid_q && res_if.result_ready_i;

  // Control FSM; RUN ends with one drain cycle (en_q low) before SCAN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      run_cnt_q <= '0;
      clr_cnt_q <= '0;
      busy_q    <= 1'b0;
      clear_q   <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            win_q     <= window_len_i;
            clr_cnt_q <= CLR_W'(CLEAR_CYCLES - 1);
            clear_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == '0) begin
            clear_q <= 1'b0;
            if (win_q == '0) begin
              state_q <= ST_SCAN;
            end else begin
              run_cnt_q <= win_q;
              en_q      <= 1'b1;
              state_q   <= ST_RUN;
            end
          end else begin
            clr_cnt_q <= clr_cnt_q - CLR_W'(1);
          end
        end
        ST_RUN: begin
          if (en_q) begin
            run_cnt_q <= run_cnt_q - WINDOW_W'(1);
            if (run_cnt_q == WINDOW_W'(1)) begin
              en_q <= 1'b0;
            end
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_last_c) begin
            sel_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ST_RESULT;
          end else begin
            sel_q <= sel_q + SEL_W'(1);
          end
        end
        ST_RESULT: begin
          if (handshake_c) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  snn_argmax_seq #(
    .COUNT_W (COUNT_W),
    .SEL_W   (SEL_W)
  ) u_argmax (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (scan_first_c),
    .step_i     (scan_c),
    .done_i     (scan_last_c),
    .idx_i      (sel_q),
    .cnt_i      (cnt_data_i),
    .best_idx_o (res_if.result_class_o),
    .best_cnt_o (res_if.result_count_o),
    .tie_o      (res_if.result_tie_o)
  );

`ifdef SNN_CTRL_PERF_CNT_EN
  logic [15:0] infer_q;

  // Saturating count of completed result handshakes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      infer_q <= '0;
    end else if (handshake_c && (infer_q != 16'hFFFF)) begin
      infer_q <= infer_q + 16'd1;
    end
  end

  assign infer_cnt_o = infer_q;
`else
  assign infer_cnt_o = 16'h0000;
`endif

  assign busy_o                = busy_q;
  assign net_clear_o           = clear_q;
  assign net_en_o              = en_q;
  assign cnt_sel_o             = sel_q;
  assign res_if.result_valid_o = valid_q;

endmodule

// File: doc/snn_inference_ctrl.md
Name: snn_inference_ctrl

Overview:
Sequences one inference of the spiking network (hidden LIF layer → output LIF layer → per-class spike counters).
- Handshake from host side; pulses clear to LIF neurons and spike counters; gates the network for a programmable window of timesteps.
- Then scans the NUM_CLASSES spike counters one per cycle, computes the argmax class, and holds the result on a valid/ready interface.
- Sits between the top-level pin wrapper and the network/counter datapath, replacing free-running operation.

Parameters:
NUM_CLASSES, 10, number of output neurons/spike counters scanned
COUNT_W, 6, width of each spike count
WINDOW_W, 8, width of timestep window length
SEL_W, 4, width of counter select index (must satisfy 2^SEL_W >= NUM_CLASSES)
CLEAR_CYCLES, 2, cycles net_clear_o is held high before the window starts (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  request an inference; accepted only in IDLE
window_len_i  in  WINDOW_W  timesteps to run; sampled on accepted start
busy_o  out  1  high in every state except IDLE
net_clear_o  out  1  synchronous clear to LIF membranes/thresholds and spike counters
net_en_o  out  1  network advance enable, one timestep per cycle high
cnt_sel_o  out  SEL_W  spike counter index being read
cnt_data_i  in  COUNT_W  count of counter cnt_sel_o, combinational, valid same cycle
result_valid_o  out  1  result available
result_ready_i  in  1  consumer accepts result
result_class_o  out  SEL_W  winning class index
result_count_o  out  COUNT_W  winning spike count
result_tie_o  out  1  another class equalled the winning count
infer_cnt_o  out  16  completed-inference counter (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1) outputs: state IDLE; busy_o, net_clear_o, net_en_o, result_valid_o, result_tie_o = 0; cnt_sel_o, result_class_o, result_count_o, infer_cnt_o = 0.
- States: IDLE, CLEAR, RUN, SCAN, RESULT. All outputs registered.
- IDLE:
  - start_i=1 latches window_len_i into win_q and moves to CLEAR next cycle.
  - start_i while busy is ignored, not queued.
- CLEAR:
  - net_clear_o=1 for exactly CLEAR_CYCLES cycles; net_en_o=0.
  - Then RUN, or SCAN directly if win_q==0.
- RUN:
  - net_en_o=1 for exactly win_q consecutive cycles; internal down-counter loaded with win_q.
  - After the last enabled cycle, one drain cycle with net_en_o=0 so the final counter increment settles; then SCAN.
- SCAN:
  - cnt_sel_o steps 0..NUM_CLASSES-1, one per cycle; cnt_data_i sampled each cycle.
  - Running max updates only on strictly greater count, so the lowest index wins ties.
  - tie flag: set when an equal count is seen; cleared when a new strict max is found.
  - Duration exactly NUM_CLASSES cycles. Then RESULT with result_class_o/count/tie loaded.
  - cnt_sel_o returns to 0 in RESULT.
- RESULT:
  - result_valid_o=1; payload stable until the cycle result_valid_o&&result_ready_i, then IDLE.
  - A start_i in that same cycle is not accepted.
  - Payload retained after handshake until the next SCAN completes; result_valid_o drops.
- Latency, start accepted to result_valid_o: CLEAR_CYCLES + win_q + 1 + NUM_CLASSES (+0 RUN/drain when win_q==0, i.e. CLEAR_CYCLES + NUM_CLASSES).
- All counts zero: class 0, count 0, tie=1 (when NUM_CLASSES>1).
- Counter saturation belongs to the spike counter; the controller treats cnt_data_i as unsigned.
- Reset mid-operation: immediate return to IDLE with reset values. net_en_o and net_clear_o drop asynchronously.

Optional Feature:
SNN_CTRL_PERF_CNT_EN
- Defined: infer_cnt_o increments by 1 on each result handshake, saturating at 16'hFFFF; cleared only by rst_i.
- Undefined: counter logic absent; infer_cnt_o tied to 0; port list unchanged.

Decomposition:
- Shared package snn_pkg:
  - state enum type for IDLE/CLEAR/RUN/SCAN/RESULT.
  - default NUM_CLASSES, COUNT_W, SEL_W constants, reused by the spike counter and top level.
- One sub-module, snn_argmax_seq: sequential compare/accumulate of (index, count); start/step/done inputs; outputs best index, best count, tie.
- FSM, window counter and handshake stay in snn_inference_ctrl.

Test Plan:
- Reset mid-RUN: start, window_len=5, assert rst_i during 3rd net_en_o cycle → all outputs 0 within the same cycle; state IDLE; no result_valid_o.
- Basic run: window_len=4, CLEAR_CYCLES=2, counts {3,7,1,0,...} on sel 0..9 → net_clear_o high 2 cycles; net_en_o high exactly 4 cycles; result_valid_o 17 cycles after start; class=1, count=7, tie=0.
- Tie and zero window:
  - counts {0,5,2,5,...}, window_len=3 → class=1, count=5, tie=1.
  - window_len=0 → net_en_o never high; result after 12 cycles; all-zero counts give class=0, count=0, tie=1.
- Backpressure: hold result_ready_i=0 for 20 cycles, pulse start_i during RESULT → payload stable and busy_o=1 throughout, start ignored; ready=1 → valid drops next cycle; state IDLE.
- Back-to-back: new start the cycle after handshake with different counts → second result correct; with SNN_CTRL_PERF_CNT_EN, infer_cnt_o=2; without it, infer_cnt_o stays 0.
